guess_fsm: RTL and testbench
============================

Name: guess_fsm

Overview:
- Moore state machine for a four-button "guess the lit LED" game.
- While no button is pressed, a one-hot pattern on y rotates one position per clock.
- A button press matching the lit position enters WIN; any other non-zero press enters LOSE.
- Sits between debounced push-button inputs and board LEDs / win-lose indicators.

Parameters:
- None. Width fixed at 4 buttons / 4 LEDs.

Ports:
- clk    input   1  system clock; all state updates on rising edge
- reset  input   1  asynchronous, active-low reset (0 = reset)
- b      input   4  button vector; bit i = button i pressed (assumed debounced, synchronous to clk)
- y      output  4  one-hot position indicator
- win    output  1  high while in WIN state
- lose   output  1  high while in LOSE state

Behaviour:
- States: S0, S1, S2, S3, WIN, LOSE. Encoding is free; outputs depend on state only (Moore, no combinational path from b to outputs).
- Reset:
  - reset=0 asynchronously forces S0 at any time, including mid-game or in WIN/LOSE.
  - While in reset, outputs are y=4'b0001, win=0, lose=0.
  - First transition occurs on the first rising clk edge after reset returns to 1.
- Outputs per state:
  - Si (i=0..3): y has only bit i set (S0=0001, S1=0010, S2=0100, S3=1000); win=0, lose=0.
  - WIN: y=0000, win=1, lose=0.
  - LOSE: y=0000, win=0, lose=1.
  - win and lose are never both 1.
- Transitions from Si, evaluated on each rising clk edge:
  - b==4'b0000 -> S((i+1) mod 4). S3 wraps to S0.
  - b exactly equals the one-hot code of i -> WIN.
  - Any other non-zero b, including multiple bits set even if bit i is among them -> LOSE.
- Transitions from WIN/LOSE:
  - Stay while b != 0.
  - b==0 -> S0 on the next edge.
- Latency: a press sampled at edge k shows on win/lose immediately after edge k. Rotation advances exactly one position per clock while idle.
- Simultaneous events: reset dominates everything. Clock and input changes are ignored while reset=0.

Test Plan:
- Reset and rotation: pulse reset=0 then release with b=0000; y sequence per clock is 0001, 0010, 0100, 1000, 0001; win=lose=0 throughout.
- Correct guess: after reset (state S0), b=0001 for 2 clocks -> win=1, y=0000, holds while b held; release b=0000 -> next clock y=0001, win=0.
- Wrong guess: after reset (S0), b=0100 -> next edge lose=1, win=0, y=0000; hold 2 clocks, lose stays 1; b=0000 -> S0, then rotation resumes 0010, 0100.
- Late correct guess: from reset, b=0000 for 3 clocks (reaches S3, y=1000), then b=1000 -> win=1; b=0000 -> y=0001 next clock.
- Multi-button: in S1 (y=0010) apply b=0011 -> lose=1.
- Async reset mid-state: while in WIN with b=0001 held, drive reset=0 between clock edges -> y=0001, win=0 immediately without waiting for a clk edge.

Source files
------------

// File: rtl/guess_fsm_if.sv
// ---------------------------------------------------------------------------
// guess_fsm_if -- button/indicator bundle for the guess-the-LED game.
//
// Signals:
//   b     [3:0]  button vector, bit i = button i pressed (debounced, clk-synchronous)
//   y     [3:0]  one-hot lit-LED position (all zero in WIN/LOSE)
//   win          high while the game sits in WIN
//   lose         high while the game sits in LOSE
//
// Modports:
//   master -- the button side (drives b, observes the indicators)
//   slave  -- the game FSM (consumes b, drives the indicators)
// ---------------------------------------------------------------------------
interface guess_fsm_if;
  logic [3:0] b;
  logic [3:0] y;
  logic       win;
  logic       lose;

  modport master (output b, input y, win, lose);
  modport slave  (input b, output y, win, lose);
endinterface : guess_fsm_if

// File: rtl/guess_fsm.sv
// ---------------------------------------------------------------------------
// guess_fsm -- Moore state machine for a four-button "guess the lit LED" game.
//
// While no button is pressed the lit LED rotates one position per clock.
// Pressing exactly the button under the lit LED enters WIN; any other
// non-zero press (including several buttons at once) enters LOSE. WIN and
// LOSE are held while any button stays down and return to S0 once all
// buttons are released.
//
// Ports:
//   clk    -- system clock, all state updates on the rising edge
//   reset  -- asynchronous, active-low reset; forces S0 (y=0001)
//   io     -- guess_fsm_if.slave: b in; y, win, lose out
//
// Outputs are decoded from the state register only, so there is no
// combinational path from b to y/win/lose.
// ---------------------------------------------------------------------------
module guess_fsm (
  input  logic        clk,
  input  logic        reset,
  guess_fsm_if.slave  io
);

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    WIN  = 3'd4,
    LOSE = 3'd5
  } state_e;

  state_e     state_q;
  state_e     state_d;

  logic [3:0] y_d;
  logic       win_d;
  logic       lose_d;

  // One-hot code of the LED lit in the current rotation state; only
  // meaningful in S0..S3 and used to judge a single-button guess.
  logic [3:0] lit_code;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every variable written here gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    lit_code = 4'b0000;

    case (state_q)
      S0, S1, S2, S3: begin
        lit_code = 4'b0001 << state_q[1:0];
        if (io.b == 4'b0000) begin
          // Idle: advance the lit LED, S3 wraps back to S0.
          state_d = state_e'({1'b0, state_q[1:0] + 2'd1});
        end else if (io.b == lit_code) begin
          state_d = WIN;
        end else begin
          // Any other press, including a multi-button press that happens
          // to contain the lit position, is a wrong guess.
          state_d = LOSE;
        end
      end

      WIN, LOSE: begin
        // Hold the verdict until every button is released.
        if (io.b == 4'b0000) begin
          state_d = S0;
        end
      end

      default: begin
        // Unused encodings recover to the start of the game.
        state_d = S0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Moore output decode
  // -------------------------------------------------------------------------
  always_comb begin
    y_d    = 4'b0000;
    win_d  = 1'b0;
    lose_d = 1'b0;

    case (state_q)
      S0:      y_d    = 4'b0001;
      S1:      y_d    = 4'b0010;
      S2:      y_d    = 4'b0100;
      S3:      y_d    = 4'b1000;
      WIN:     win_d  = 1'b1;
      LOSE:    lose_d = 1'b1;
      default: y_d    = 4'b0000;
    endcase
  end

  assign io.y    = y_d;
  assign io.win  = win_d;
  assign io.lose = lose_d;

endmodule : guess_fsm

// File: tb/tb_guess_fsm.sv
// ---------------------------------------------------------------------------
// tb_guess_fsm -- self-checking bench for guess_fsm.
//
// Directed scenarios cover reset, rotation, correct/wrong/late guesses,
// multi-button presses and asynchronous reset in WIN. A randomized phase
// then compares the DUT against a game-level reference model (lit position
// plus a verdict flag) every clock, with occasional asynchronous resets.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_guess_fsm;

  logic clk;
  logic reset;

  guess_fsm_if bus ();

  guess_fsm dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the lit position and the current verdict.
  // verdict: 0 = still guessing, 1 = won, 2 = lost.
  int model_pos     = 0;
  int model_verdict = 0;

  // Expected {y, win, lose}.
  function automatic logic [5:0] model_exp();
    logic [3:0] y;
    y = (model_verdict == 0) ? 4'(1 << model_pos) : 4'b0000;
    return {y, model_verdict == 1, model_verdict == 2};
  endfunction

  function automatic void model_reset();
    model_pos     = 0;
    model_verdict = 0;
  endfunction

  function automatic void model_clock(input logic [3:0] bv);
    if (model_verdict != 0) begin
      if (bv == 4'b0000) begin
        model_verdict = 0;
        model_pos     = 0;
      end
    end else if (bv == 4'b0000) begin
      model_pos = (model_pos + 1) % 4;
    end else if (bv == 4'(1 << model_pos)) begin
      model_verdict = 1;
    end else begin
      model_verdict = 2;
    end
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got y=%b win=%b lose=%b, want y=%b win=%b lose=%b",
               tag, obs[5:2], obs[1], obs[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {bus.y, bus.win, bus.lose};
  endfunction

  // Apply b, take one clock, compare against the given expectation.
  task automatic step(input logic [3:0] bv, input string tag, input logic [5:0] exp);
    bus.b = bv;
    @(posedge clk);
    model_clock(bv);
    #1;
    check(tag, dut_out(), exp);
  endtask

  // Same as step, but the expectation comes from the reference model.
  task automatic step_model(input logic [3:0] bv, input string tag);
    bus.b = bv;
    @(posedge clk);
    model_clock(bv);
    #1;
    check(tag, dut_out(), model_exp());
  endtask

  // Assert reset between edges, check the immediate effect, hold it across
  // a clock edge with buttons changing, then release at the falling edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check({tag, "_now"}, dut_out(), 6'b0001_00);
    bus.b = 4'($urandom_range(1, 15));
    @(posedge clk);
    #1;
    check({tag, "_held"}, dut_out(), 6'b0001_00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Safety net: the bench only waits on its own clock, but never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] bv;
    int         r;

    reset = 1'b0;
    bus.b = 4'b0000;
    #2;
    check("reset_val", dut_out(), 6'b0001_00);
    bus.b = 4'b0100;
    @(posedge clk);
    #1;
    check("reset_ignores_clk", dut_out(), 6'b0001_00);
    bus.b = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Reset and rotation.
    step(4'b0000, "rot_s1", 6'b0010_00);
    step(4'b0000, "rot_s2", 6'b0100_00);
    step(4'b0000, "rot_s3", 6'b1000_00);
    step(4'b0000, "rot_wrap", 6'b0001_00);

    // Correct guess in S0, held, then released.
    step(4'b0001, "win_enter", 6'b0000_10);
    step(4'b0001, "win_hold", 6'b0000_10);
    step(4'b0000, "win_release", 6'b0001_00);

    // Wrong guess in S0, held, released, rotation resumes.
    step(4'b0100, "lose_enter", 6'b0000_01);
    step(4'b0100, "lose_hold1", 6'b0000_01);
    step(4'b0100, "lose_hold2", 6'b0000_01);
    step(4'b0000, "lose_release", 6'b0001_00);
    step(4'b0000, "lose_rot_s1", 6'b0010_00);
    step(4'b0000, "lose_rot_s2", 6'b0100_00);

    // Late correct guess in S3.
    async_reset("rst_mid_rot");
    step(4'b0000, "late_s1", 6'b0010_00);
    step(4'b0000, "late_s2", 6'b0100_00);
    step(4'b0000, "late_s3", 6'b1000_00);
    step(4'b1000, "late_win", 6'b0000_10);
    step(4'b0000, "late_release", 6'b0001_00);

    // Multi-button press containing the lit bit in S1.
    step(4'b0000, "multi_s1", 6'b0010_00);
    step(4'b0011, "multi_lose", 6'b0000_01);
    step(4'b0000, "multi_release", 6'b0001_00);

    // Asynchronous reset while in WIN with the button held.
    step(4'b0001, "win_before_rst", 6'b0000_10);
    bus.b = 4'b0001;
    async_reset("rst_in_win");
    step(4'b0000, "after_rst_s1", 6'b0010_00);

    // Randomized phase against the reference model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        bv = 4'b0000;
      end else if (r < 75) begin
        bv = 4'(1 << $urandom_range(0, 3));
      end else begin
        bv = 4'($urandom_range(1, 15));
      end
      step_model(bv, "rand");
      if ($urandom_range(0, 99) < 3) begin
        async_reset("rand_rst");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_guess_fsm
